// File: rtl/hilo_issue_ctrl.sv
// HI/LO issue controller between the EX stage and the multiply/divide unit.
// Handles request stalling, architectural HI/LO storage and the unit's handshakes.
module hilo_issue_ctrl #(
  parameter int LAT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [2:0]       req_op,
  input  logic [31:0]      req_rs,
  input  logic [31:0]      req_rt,
  output logic             req_ready,
  output logic [31:0]      rd_data,
  output logic             busy,
  output logic [LAT_W-1:0] last_lat,
  output logic [31:0]      md_in_src0,
  output logic [31:0]      md_in_src1,
  output logic [1:0]       md_in_op,
  output logic             md_in_sign,
  output logic             md_in_valid,
  input  logic             md_in_ready,
  output logic             md_out_ready,
  input  logic             md_out_valid,
  input  logic [31:0]      md_out_res0,
  input  logic [31:0]      md_out_res1,
  output logic [1:0]       dbg_state
);

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; valid never depends on ready and is held until the transfer.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [LAT_W-1:0] lat_cnt;
  logic [LAT_W-1:0] lat_cnt_inc;
  logic             accept;
  logic             md_start;
  logic             mt_hi;
  logic             mt_lo;
  logic             in_fire;
  logic             out_fire;

  assign req_ready    = reset && (state == S_IDLE);
  assign md_in_valid  = (state == S_ISSUE);
  assign md_out_ready = (state == S_WAIT);
  assign dbg_state    = state;

  assign accept      = req_valid && req_ready;
  assign md_start    = accept && !req_op[2];
  assign mt_hi       = accept && (req_op == 3'd4);
  assign mt_lo       = accept && (req_op == 3'd5);
  assign in_fire     = md_in_valid && md_in_ready;
  assign out_fire    = md_out_valid && md_out_ready;
  assign lat_cnt_inc = (&lat_cnt) ? lat_cnt : lat_cnt + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (md_start) state_nxt = S_ISSUE;
      S_ISSUE: if (in_fire)  state_nxt = S_WAIT;
      S_WAIT:  if (out_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Reads see the stored value; a same-cycle MTHI/MTLO shows up one cycle later.
  always_comb begin
    rd_data = '0;
    case (req_op)
      3'd6:    rd_data = hi_q;
      3'd7:    rd_data = lo_q;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_IDLE);
    end
  end

  // Operands and op code are frozen at accept so the offer stays stable in ISSUE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_in_src0 <= '0;
      md_in_src1 <= '0;
      md_in_op   <= 2'b00;
      md_in_sign <= 1'b0;
    end else if (md_start) begin
      md_in_src0 <= req_rs;
      md_in_src1 <= req_rt;
      md_in_op   <= req_op[1] ? 2'b10 : 2'b01;
      md_in_sign <= !req_op[0];
    end else if (out_fire) begin
      md_in_op   <= 2'b00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_cnt  <= '0;
      last_lat <= '0;
    end else begin
      if (md_start) begin
        lat_cnt <= '0;
      end else if (state != S_IDLE) begin
        lat_cnt <= lat_cnt_inc;
      end
      if (out_fire) begin
        last_lat <= lat_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (out_fire) begin
      hi_q <= md_out_res1;
      lo_q <= md_out_res0;
    end else begin
      if (mt_hi) hi_q <= req_rs;
      if (mt_lo) lo_q <= req_rs;
    end
  end

endmodule

// File: tb/tb_hilo_issue_ctrl.sv
// Bench for hilo_issue_ctrl: a sequential unit model answers the offers and
// HI/LO results are checked against an expected queue through MFHI/MFLO reads.
module tb_hilo_issue_ctrl;

  localparam int LAT_W = 16;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic [2:0]       req_op;
  logic [31:0]      req_rs;
  logic [31:0]      req_rt;
  logic             req_ready;
  logic [31:0]      rd_data;
  logic             busy;
  logic [LAT_W-1:0] last_lat;
  logic [31:0]      md_in_src0;
  logic [31:0]      md_in_src1;
  logic [1:0]       md_in_op;
  logic             md_in_sign;
  logic             md_in_valid;
  logic             md_in_ready;
  logic             md_out_ready;
  logic             md_out_valid;
  logic [31:0]      md_out_res0;
  logic [31:0]      md_out_res1;
  logic [1:0]       dbg_state;

  logic [63:0] exp_q[$];
  int total;
  int bad;

  hilo_issue_ctrl #(.LAT_W(LAT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
    .req_ready(req_ready), .rd_data(rd_data), .busy(busy), .last_lat(last_lat),
    .md_in_src0(md_in_src0), .md_in_src1(md_in_src1), .md_in_op(md_in_op),
    .md_in_sign(md_in_sign), .md_in_valid(md_in_valid), .md_in_ready(md_in_ready),
    .md_out_ready(md_out_ready), .md_out_valid(md_out_valid),
    .md_out_res0(md_out_res0), .md_out_res1(md_out_res1), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of the multiply/divide unit: {HI, LO}.
  function automatic logic [63:0] md_model(input logic [1:0] op, input logic sign,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0] p;
    sa = sign ? {{32{a[31]}}, a} : {32'b0, a};
    sb = sign ? {{32{b[31]}}, b} : {32'b0, b};
    if (op == 2'b01) begin
      p = sa * sb;
      return p;
    end
    if (op != 2'b10) return 64'hBAD0_BAD0_BAD0_BAD0;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (sign) return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    return {a % b, a / b};
  endfunction

  task automatic read_hilo(input string tag, input logic [63:0] exp);
    req_valid = 1'b1;
    req_op = 3'd6;
    #1 check({tag, "_hi"}, {32'b0, rd_data}, {32'b0, exp[63:32]});
    req_op = 3'd7;
    #1 check({tag, "_lo"}, {32'b0, rd_data}, {32'b0, exp[31:0]});
    req_valid = 1'b0;
    req_op = 3'd0;
  endtask

  // One full mul/div transaction: accept, offer (with stall), wait, capture.
  task automatic run_md(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int in_stall, input int out_delay, input bit probe_mf,
                        input logic [63:0] exp);
    logic [1:0]  e_op;
    logic        e_sign;
    logic [63:0] res;
    logic [63:0] want;
    int          edges;
    e_op = op[1] ? 2'b10 : 2'b01;
    e_sign = ~op[0];
    @(negedge clk);
    check("req_ready_idle", {63'b0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_op = op;
    req_rs = rs;
    req_rt = rt;
    md_in_ready = 1'b0;
    exp_q.push_back(exp);
    @(negedge clk);
    edges = 0;
    req_valid = probe_mf;
    req_op = probe_mf ? 3'd6 : 3'd0;
    req_rs = ~rs;
    req_rt = ~rt;
    check("busy_issue", {63'b0, busy}, 64'd1);
    check("in_op", {62'b0, md_in_op}, {62'b0, e_op});
    check("in_sign", {63'b0, md_in_sign}, {63'b0, e_sign});
    check("src0", {32'b0, md_in_src0}, {32'b0, rs});
    check("src1", {32'b0, md_in_src1}, {32'b0, rt});
    check("in_valid", {63'b0, md_in_valid}, 64'd1);
    check("req_ready_busy", {63'b0, req_ready}, 64'd0);
    for (int i = 0; i < in_stall; i++) begin
      @(negedge clk);
      edges++;
      check("in_valid_hold", {63'b0, md_in_valid}, 64'd1);
      check("src0_hold", {32'b0, md_in_src0}, {32'b0, rs});
      check("op_hold", {62'b0, md_in_op}, {62'b0, e_op});
    end
    md_in_ready = 1'b1;
    res = md_model(md_in_op, md_in_sign, md_in_src0, md_in_src1);
    @(negedge clk);
    edges++;
    md_in_ready = 1'b0;
    check("in_valid_drop", {63'b0, md_in_valid}, 64'd0);
    check("out_ready_wait", {63'b0, md_out_ready}, 64'd1);
    check("state_wait", {62'b0, dbg_state}, 64'd2);
    for (int i = 0; i < out_delay; i++) begin
      @(negedge clk);
      edges++;
      check("out_ready_hold", {63'b0, md_out_ready}, 64'd1);
      if (probe_mf) check("mf_stalled", {63'b0, req_ready}, 64'd0);
    end
    md_out_valid = 1'b1;
    md_out_res0 = res[31:0];
    md_out_res1 = res[63:32];
    @(negedge clk);
    edges++;
    md_out_valid = 1'b0;
    md_out_res0 = 32'hA5A5_A5A5;
    md_out_res1 = 32'h5A5A_5A5A;
    check("busy_done", {63'b0, busy}, 64'd0);
    check("op_idle", {62'b0, md_in_op}, 64'd0);
    check("last_lat", {48'b0, last_lat}, 64'(edges));
    check("state_idle", {62'b0, dbg_state}, 64'd0);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 64'd0, 64'd1);
    end else begin
      want = exp_q.pop_front();
      if (probe_mf) begin
        check("mf_ready", {63'b0, req_ready}, 64'd1);
        check("mf_new_hi", {32'b0, rd_data}, {32'b0, want[63:32]});
      end
      read_hilo("result", want);
    end
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    total = 0;
    bad = 0;
    reset = 1'b0;
    req_valid = 1'b0;
    req_op = 3'd0;
    req_rs = '0;
    req_rt = '0;
    md_in_ready = 1'b0;
    md_out_valid = 1'b0;
    md_out_res0 = '0;
    md_out_res1 = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {63'b0, req_ready}, 64'd0);
    check("rst_in_valid", {63'b0, md_in_valid}, 64'd0);
    check("rst_out_ready", {63'b0, md_out_ready}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_last_lat", {48'b0, last_lat}, 64'd0);
    check("rst_in_op", {62'b0, md_in_op}, 64'd0);
    check("rst_src", {md_in_src1, md_in_src0}, 64'd0);
    read_hilo("rst", 64'd0);
    reset = 1'b1;
    #1 check("post_rst_ready", {63'b0, req_ready}, 64'd1);

    run_md(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 0, 1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
    run_md(3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 0, 2, 1'b0, 64'h0000_0001_FFFF_FFFE);
    run_md(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1, 3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md(3'd3, 32'd100, 32'd7, 5, 0, 1'b0, {32'd2, 32'd14});

    for (int n = 0; n < 6; n++) begin
      r_op = 3'($urandom_range(0, 3));
      r_rs = $urandom;
      r_rt = 32'($urandom_range(1, 1000));
      run_md(r_op, r_rs, r_rt, $urandom_range(0, 3), $urandom_range(0, 4), 1'b0,
             md_model(r_op[1] ? 2'b10 : 2'b01, ~r_op[0], r_rs, r_rt));
    end

    // reset during WAIT aborts asynchronously and clears HI/LO
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd1;
    req_rs = 32'h0000_1234;
    req_rt = 32'h0000_5678;
    @(negedge clk);
    req_valid = 1'b0;
    md_in_ready = 1'b1;
    @(negedge clk);
    md_in_ready = 1'b0;
    check("abort_in_wait", {62'b0, dbg_state}, 64'd2);
    #2 reset = 1'b0;
    #1;
    check("abort_state", {62'b0, dbg_state}, 64'd0);
    check("abort_out_ready", {63'b0, md_out_ready}, 64'd0);
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_req_ready", {63'b0, req_ready}, 64'd0);
    read_hilo("abort", 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("abort_recover", {63'b0, req_ready}, 64'd1);

    // MTLO then MFLO
    @(negedge clk);
    req_valid = 1'b1;
    req_op = 3'd5;
    req_rs = 32'h1234_5678;
    #1 check("mtlo_rd_zero", {32'b0, rd_data}, 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("mt_busy", {63'b0, busy}, 64'd0);
    read_hilo("mtlo", {32'd0, 32'h1234_5678});

    // spurious result while IDLE must be ignored
    @(negedge clk);
    md_out_valid = 1'b1;
    md_out_res0 = 32'hDEAD_BEEF;
    md_out_res1 = 32'hCAFE_F00D;
    #1 check("spur_out_ready", {63'b0, md_out_ready}, 64'd0);
    @(negedge clk);
    md_out_valid = 1'b0;
    read_hilo("spur", {32'd0, 32'h1234_5678});

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hilo_issue_ctrl.md
Name: hilo_issue_ctrl

Overview:
- Initiator-side controller that sits between the EX stage and the multiply/divide unit.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests from the pipeline, owns the architectural HI/LO registers, and drives the unit's in_valid/in_ready and out_valid/out_ready handshakes.
- Produces the stall (req_ready) and MFHI/MFLO read data for the pipeline.

Parameters:
- LAT_W, 16, width of the saturating latency counter for the last mul/div operation.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline presents an HI/LO-class instruction.
- req_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- req_rs  in  32  rs operand (dividend/multiplicand; MTHI/MTLO data).
- req_rt  in  32  rt operand (divisor/multiplier).
- req_ready  out  1  request accepted this cycle; low = stall.
- rd_data  out  32  HI (op 6) or LO (op 7); 0 otherwise.
- busy  out  1  mul/div in flight.
- last_lat  out  LAT_W  cycles from accept to result capture of the last mul/div, saturating.
- md_in_src0  out  32  to unit: registered rs.
- md_in_src1  out  32  to unit: registered rt.
- md_in_op  out  2  2'b01 MUL, 2'b10 DIV, 2'b00 when idle.
- md_in_sign  out  1  1 for MULT/DIV.
- md_in_valid  out  1  operation offer.
- md_in_ready  in  1  unit accepts.
- md_out_ready  out  1  controller accepts result.
- md_out_valid  in  1  result available.
- md_out_res0  in  32  low product / quotient, written to LO.
- md_out_res1  in  32  high product / remainder, written to HI.

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset (reset low, async):
  - state=IDLE; HI=LO=0; src regs=0; last_lat=0.
  - md_in_valid=0, md_out_ready=0, md_in_op=0, busy=0.
  - req_ready=0 while reset is low, and =1 in IDLE afterwards.
- req_ready = (state==IDLE). MFHI/MFLO/MTHI/MTLO are stalled while busy.
- IDLE, req_valid & op 0-3:
  - Capture rs/rt into the src regs.
  - Set md_in_op/md_in_sign.
  - Clear the latency counter.
  - Next state is ISSUE.
- ISSUE:
  - md_in_valid=1, held with stable src/op/sign until md_in_valid & md_in_ready.
  - On the handshake, move to WAIT; md_in_valid drops the next cycle.
- WAIT:
  - md_out_ready=1.
  - On md_out_valid & md_out_ready: HI<=md_out_res1, LO<=md_out_res0, last_lat<=counter+1 (saturating), md_in_op<=0, state IDLE.
  - The next request can be accepted the following cycle.
- Latency counter increments every cycle in ISSUE/WAIT and saturates at all-ones.
- busy = (state!=IDLE), registered.
- MTHI/MTLO (IDLE, req_valid): HI or LO <= req_rs at the edge; single cycle; state unchanged.
- MFHI/MFLO: rd_data is combinational from current HI/LO. A write in the same cycle is not forwarded; the new value is visible the next cycle.
- md_out_valid asserted in IDLE/ISSUE is ignored: md_out_ready=0 there and HI/LO are untouched.
- Divide by zero: no trap; HI/LO take whatever the unit returns.
- reset asserted mid-operation aborts immediately to IDLE. HI/LO return to 0 and no partial write occurs.
- req_valid with req_ready low has no effect. The pipeline must hold the request.

Test Plan:
- MULT rs=0xFFFFFFFF rt=0x00000002 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; md_in_sign=1, md_in_op=01; busy high from accept to capture.
- MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE; last_lat equals the measured cycles.
- DIV rs=0xFFFFFFF9 (-7) rt=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU rs=100 rt=7 -> LO=14, HI=2.
- MFHI issued the cycle after a DIV accept -> req_ready=0 until capture. Then rd_data=new HI.
- MTLO 0x12345678, then MFLO -> rd_data=0x12345678.
- md_in_ready held low 5 cycles in ISSUE -> md_in_valid stays 1 with stable src/op.
- Asserting reset in WAIT -> state IDLE, HI=LO=0, md_out_ready=0 asynchronously.
- Spurious md_out_valid in IDLE -> HI/LO unchanged.
